// File: rtl/framebuffer_pkg.sv
// Shared definitions for the framebuffer arbiter: FSM state encoding, RAM geometry
// and the helper that builds a fetch address from (half, row, column).
package framebuffer_pkg;

  localparam int FB_DATA_WIDTH  = 16;
  localparam int FB_COLUMN_BITS = 6;
  localparam int FB_ROW_BITS    = 4;
  localparam int FB_ADDR_WIDTH  = 1 + FB_ROW_BITS + FB_COLUMN_BITS;

  localparam logic HALF_TOP    = 1'b0;
  localparam logic HALF_BOTTOM = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_TOP,
    ST_RD_BOT,
    ST_RD_LAT_TOP,
    ST_RD_LAT_BOT,
    ST_WRITE
  } fb_state_e;

  // Columns are stored mirrored in RAM, hence the inverted column field.
  function automatic logic [FB_ADDR_WIDTH-1:0] fetchAddress(
    input logic                      half,
    input logic [FB_ROW_BITS-1:0]    row,
    input logic [FB_COLUMN_BITS-1:0] column
  );
    return {half, row, ~column};
  endfunction

endpackage

// File: rtl/framebuffer_arbiter.sv
// Arbitrates the single-port framebuffer RAM: scan-out pixel-pair fetches have absolute
// priority, host writes use idle slots. Define FRAMEBUFFER_ARBITER_OVERRUN_EN for fetch_overrun.
module framebuffer_arbiter
  import framebuffer_pkg::*;
#(
  parameter int DATA_WIDTH  = FB_DATA_WIDTH,
  parameter int COLUMN_BITS = FB_COLUMN_BITS,
  parameter int ROW_BITS    = FB_ROW_BITS,
  localparam int ADDR_WIDTH = 1 + ROW_BITS + COLUMN_BITS
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic                   fetch_start,
  input  logic [COLUMN_BITS-1:0] fetch_column,
  input  logic [ROW_BITS-1:0]    fetch_row,
  output logic [DATA_WIDTH-1:0]  fetch_top,
  output logic [DATA_WIDTH-1:0]  fetch_bottom,
  output logic                   fetch_done,
`ifdef FRAMEBUFFER_ARBITER_OVERRUN_EN
  output logic                   fetch_overrun,
`endif
  input  logic                   wr_req,
  input  logic [ADDR_WIDTH-1:0]  wr_address,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   wr_ack,
  output logic [ADDR_WIDTH-1:0]  ram_address,
  output logic [DATA_WIDTH-1:0]  ram_data_out,
  input  logic [DATA_WIDTH-1:0]  ram_data_in,
  output logic                   ram_write_en,
  output logic                   ram_clk_enable
);

  fb_state_e              state_q, state_d;
  logic                   pending_q, pending_d;
  logic [COLUMN_BITS-1:0] column_q, column_d;
  logic [ROW_BITS-1:0]    row_q, row_d;
  logic [ADDR_WIDTH-1:0]  address_q, address_d;
  logic [DATA_WIDTH-1:0]  dataOut_q, dataOut_d;
  logic                   writeEn_q, writeEn_d;
  logic                   clkEnable_q, clkEnable_d;
  logic [DATA_WIDTH-1:0]  top_q, top_d;
  logic [DATA_WIDTH-1:0]  bottom_q, bottom_d;
  logic                   done_q, done_d;
  logic                   ack_q, ack_d;

  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    column_d    = column_q;
    row_d       = row_q;
    address_d   = address_q;
    dataOut_d   = dataOut_q;
    writeEn_d   = 1'b0;
    clkEnable_d = clkEnable_q;
    top_d       = top_q;
    bottom_d    = bottom_q;
    done_d      = 1'b0;
    ack_d       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          pending_d   = 1'b0;
          state_d     = ST_RD_TOP;
          clkEnable_d = 1'b1;
          address_d   = fetchAddress(HALF_TOP, row_q, column_q);
        end else if (fetch_start) begin
          column_d    = fetch_column;
          row_d       = fetch_row;
          state_d     = ST_RD_TOP;
          clkEnable_d = 1'b1;
          address_d   = fetchAddress(HALF_TOP, fetch_row, fetch_column);
        end else if (wr_req) begin
          state_d     = ST_WRITE;
          address_d   = wr_address;
          dataOut_d   = wr_data;
          writeEn_d   = 1'b1;
          clkEnable_d = 1'b1;
          ack_d       = 1'b1;
        end
      end

      ST_RD_TOP: begin
        state_d   = ST_RD_BOT;
        address_d = fetchAddress(HALF_BOTTOM, row_q, column_q);
      end

      ST_RD_BOT: begin
        state_d = ST_RD_LAT_TOP;
        top_d   = ram_data_in;
      end

      ST_RD_LAT_TOP: begin
        state_d     = ST_RD_LAT_BOT;
        bottom_d    = ram_data_in;
        done_d      = 1'b1;
        clkEnable_d = 1'b0;
      end

      // A start arriving here chains directly into the next fetch, giving one fetch per 4 cycles.
      ST_RD_LAT_BOT: begin
        if (fetch_start) begin
          column_d    = fetch_column;
          row_d       = fetch_row;
          state_d     = ST_RD_TOP;
          clkEnable_d = 1'b1;
          address_d   = fetchAddress(HALF_TOP, fetch_row, fetch_column);
        end else begin
          state_d = ST_IDLE;
        end
      end

      // The write slot cannot be reused: a start here is parked and launched from IDLE one edge later.
      ST_WRITE: begin
        state_d     = ST_IDLE;
        clkEnable_d = 1'b0;
        if (fetch_start) begin
          pending_d = 1'b1;
          column_d  = fetch_column;
          row_d     = fetch_row;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        clkEnable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      column_q    <= '0;
      row_q       <= '0;
      address_q   <= '0;
      dataOut_q   <= '0;
      writeEn_q   <= 1'b0;
      clkEnable_q <= 1'b0;
      top_q       <= '0;
      bottom_q    <= '0;
      done_q      <= 1'b0;
      ack_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      column_q    <= column_d;
      row_q       <= row_d;
      address_q   <= address_d;
      dataOut_q   <= dataOut_d;
      writeEn_q   <= writeEn_d;
      clkEnable_q <= clkEnable_d;
      top_q       <= top_d;
      bottom_q    <= bottom_d;
      done_q      <= done_d;
      ack_q       <= ack_d;
    end
  end

  assign fetch_top      = top_q;
  assign fetch_bottom   = bottom_q;
  assign fetch_done     = done_q;
  assign wr_ack         = ack_q;
  assign ram_address    = address_q;
  assign ram_data_out   = dataOut_q;
  assign ram_write_en   = writeEn_q;
  assign ram_clk_enable = clkEnable_q;

`ifdef FRAMEBUFFER_ARBITER_OVERRUN_EN
  logic startDropped;
  logic overrun_q;

  // A start is lost while a fetch is in flight or one is already parked.
  always_comb begin
    startDropped = fetch_start &&
                   (pending_q || (state_q == ST_RD_TOP) ||
                    (state_q == ST_RD_BOT) || (state_q == ST_RD_LAT_TOP));
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_q | startDropped;
    end
  end

  assign fetch_overrun = overrun_q;
`endif

endmodule
